// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types, constants and round functions for the SHA-256/224
// stream core.
//   word_t    32-bit word
//   hstate_t  eight working words; element 0 is 'a' / H0 and sits in the MSBs,
//             so a packed hstate_t is already the big-endian digest layout.
//   state_t   control FSM states
//   K, IV256, IV224 and ch/maj/bsig0/bsig1/ssig0/ssig1.
package sha256_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [0:7] hstate_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_COMP,
        ST_UPD,
        ST_OUT
    } state_t;

    localparam hstate_t IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam hstate_t IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round.
//   st_in   working state a..h before the round
//   wt      message schedule word for this round
//   kt      round constant for this round
//   st_out  working state a..h after the round
module sha256_round
    import sha256_pkg::*;
(
    input  hstate_t st_in,
    input  word_t   wt,
    input  word_t   kt,
    output hstate_t st_out
);

    word_t t1;
    word_t t2;

    always_comb begin
        t1     = st_in[7] + bsig1(st_in[4]) + ch(st_in[4], st_in[5], st_in[6]) + kt + wt;
        t2     = bsig0(st_in[0]) + maj(st_in[0], st_in[1], st_in[2]);
        st_out = {t1 + t2, st_in[0], st_in[1], st_in[2],
                  st_in[3] + t1, st_in[4], st_in[5], st_in[6]};
    end

endmodule

// File: rtl/sha256_stream_core.sv
// sha256_stream_core: streaming SHA-256 / SHA-224 engine. Accepts a byte
// message as big-endian 32-bit beats, pads it internally, compresses any
// number of 512-bit blocks and presents the digest over valid/ready.
//   clk, reset                  clock, asynchronous active-low reset
//   mode_224                    SHA-224 select, sampled on the first beat
//   in_data/in_valid/in_ready   message beat handshake
//   in_last, in_bytes           final beat marker and its byte count (0..4)
//   digest/digest_valid/digest_ready  result handshake; SHA-224 in [255:32]
// Parameters: UNROLL rounds per clock (1, 2 or 4); LEN_W bit-length counter
// width (32..64), zero-extended into the 64-bit length field.
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int UNROLL = 1,
    parameter int LEN_W  = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mode_224,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready
);

    state_t           state;
    hstate_t          h_reg;
    hstate_t          wv;
    hstate_t          h_sum;
    logic [LEN_W-1:0] len;
    logic [63:0]      len64;
    logic [3:0]       widx;
    logic [5:0]       pad_pos;     // byte offset of the 0x80 marker in the block
    logic [5:0]       rnd;         // index of the first round done this cycle
    logic             final_blk;
    logic             need_extra;
    logic             pad_after;   // message ended exactly on a block boundary
    logic             mode224;

    word_t w       [0:15];
    word_t w_pad   [0:15];
    word_t w_sched [0:15];
    word_t wt      [0:UNROLL-1];
    word_t kt      [0:UNROLL-1];
    hstate_t st    [0:UNROLL];

    logic       beat;
    logic [2:0] nb;
    logic       beat_to_comp;
    logic       extra_blk;
    logic       load_wv;

    assign beat         = in_valid && in_ready;
    assign nb           = !in_last ? 3'd4 : ((in_bytes > 3'd4) ? 3'd4 : in_bytes);
    assign beat_to_comp = beat && (widx == 4'd15) && (!in_last || nb == 3'd4);
    assign extra_blk    = (state == ST_UPD) && !final_blk && need_extra;
    assign load_wv      = beat_to_comp || (state == ST_PAD) || extra_blk;
    assign len64        = 64'(len);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            h_sum[i] = h_reg[i] + wv[i];
        end
    end

    // Padding: clear every byte from pad_pos onwards, drop in the 0x80 marker,
    // and append the length when it still fits in this block.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so that no
        // path leaves it unassigned and a latch is never inferred.
        w_pad = w;
        for (int j = 0; j < 16; j++) begin
            if (j > int'(pad_pos[5:2])) begin
                w_pad[j] = '0;
            end else if (j == int'(pad_pos[5:2])) begin
                w_pad[j] = (w[j] & ~(32'hffff_ffff >> {pad_pos[1:0], 3'b000}))
                         | (32'h8000_0000 >> {pad_pos[1:0], 3'b000});
            end
        end
        if (pad_pos <= 6'd55) begin
            w_pad[14] = len64[63:32];
            w_pad[15] = len64[31:0];
        end
    end

    // Message schedule over a 16-word circular window. Slot t%16 holds
    // W[t-16] until round t overwrites it with W[t].
    always_comb begin
        w_sched = w;
        for (int u = 0; u < UNROLL; u++) begin
            logic [5:0] t;
            logic [3:0] i2, i7, i15;
            t   = rnd + 6'(u);
            i2  = t[3:0] - 4'd2;
            i7  = t[3:0] - 4'd7;
            i15 = t[3:0] - 4'd15;
            kt[u] = K[t];
            if (t < 6'd16) begin
                wt[u] = w_sched[t[3:0]];
            end else begin
                // NOTE: blocking updates of the local window are deliberate so a
                // later round in the same cycle sees W[t-2] produced just above.
                wt[u] = ssig1(w_sched[i2]) + w_sched[i7] + ssig0(w_sched[i15])
                      + w_sched[t[3:0]];
                w_sched[t[3:0]] = wt[u];
            end
        end
    end

    assign st[0] = wv;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        sha256_round u_round (
            .st_in  (st[u]),
            .wt     (wt[u]),
            .kt     (kt[u]),
            .st_out (st[u+1])
        );
    end

    // Block buffer and working registers.
    // NOTE: pure datapath storage has no reset; control flags guarantee it is
    // always written before being read, so resetting it buys nothing.
    always_ff @(posedge clk) begin
        if (beat) begin
            w[widx] <= in_data;
        end
        case (state)
            ST_PAD:  w <= w_pad;
            ST_COMP: begin
                w  <= w_sched;
                wv <= st[UNROLL];
            end
            ST_UPD: begin
                if (extra_blk) begin
                    for (int j = 0; j < 14; j++) begin
                        w[j] <= '0;
                    end
                    w[14] <= len64[63:32];
                    w[15] <= len64[31:0];
                end
            end
            default: ;
        endcase
        if (load_wv) begin
            wv <= (state == ST_UPD) ? h_sum : h_reg;
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b0;
            digest_valid <= 1'b0;
            digest       <= '0;
            len          <= '0;
            h_reg        <= IV256;
            widx         <= '0;
            pad_pos      <= '0;
            rnd          <= '0;
            final_blk    <= 1'b0;
            need_extra   <= 1'b0;
            pad_after    <= 1'b0;
            mode224      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (beat) begin
                        mode224 <= mode_224;
                        h_reg   <= mode_224 ? IV224 : IV256;
                    end
                end
                ST_PAD: begin
                    state <= ST_COMP;
                    if (pad_pos <= 6'd55) final_blk  <= 1'b1;
                    else                  need_extra <= 1'b1;
                end
                ST_COMP: begin
                    rnd <= rnd + 6'(UNROLL);   // wraps back to 0 after round 63
                    if (rnd == 6'(64 - UNROLL)) state <= ST_UPD;
                end
                ST_UPD: begin
                    h_reg <= h_sum;
                    if (final_blk) begin
                        state <= ST_OUT;
                    end else if (need_extra) begin
                        need_extra <= 1'b0;
                        final_blk  <= 1'b1;
                        state      <= ST_COMP;
                    end else if (pad_after) begin
                        pad_after <= 1'b0;
                        state     <= ST_PAD;
                    end else begin
                        state    <= ST_LOAD;
                        in_ready <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (!digest_valid) begin
                        digest_valid <= 1'b1;
                        digest       <= mode224 ? {h_reg[0:6], 32'h0} : h_reg;
                    end else if (digest_ready) begin
                        digest_valid <= 1'b0;
                        state        <= ST_IDLE;
                        in_ready     <= 1'b1;
                        len          <= '0;
                        widx         <= '0;
                        final_blk    <= 1'b0;
                        need_extra   <= 1'b0;
                        pad_after    <= 1'b0;
                    end
                end
                default: ;   // ST_LOAD only reacts to beats, handled below
            endcase

            // Beats arrive only in IDLE/LOAD; this overrides the defaults above.
            if (beat) begin
                len  <= len + LEN_W'({nb, 3'b000});
                widx <= widx + 4'd1;
                if (in_last) begin
                    in_ready <= 1'b0;
                    if (widx == 4'd15 && nb == 3'd4) begin
                        state     <= ST_COMP;
                        pad_after <= 1'b1;
                        pad_pos   <= '0;
                    end else begin
                        state   <= ST_PAD;
                        pad_pos <= {widx, 2'b00} + 6'(nb);
                    end
                end else if (widx == 4'd15) begin
                    state    <= ST_COMP;
                    in_ready <= 1'b0;
                end else begin
                    state <= ST_LOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// tb_sha256_stream_core: directed bench for sha256_stream_core. Three
// instances (UNROLL 1, 2, 4; the last with a 32-bit length counter) share one
// stimulus stream; beats and digest acceptance are gated so all three stay in
// lockstep on their handshakes.
module tb_sha256_stream_core;

    localparam logic [255:0] EXP_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] EXP_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EXP_ABC224 =
        256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] EXP_56 =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] EXP_112 =
        256'hcf5b16a7_78af8380_036ce59e_7b049237_0b249b11_e8f07a51_afac4503_7afee9d1;

    logic         clk = 1'b0;
    logic         reset;
    logic         mode_224;
    logic [31:0]  in_data;
    logic         in_valid_drv;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         digest_ready_drv;

    logic [255:0] dg  [0:2];
    logic         rdy [0:2];
    logic         dv  [0:2];
    logic         all_rdy;
    logic         all_dv;
    logic         in_valid_g;
    logic         digest_ready_g;

    int passed = 0;
    int total  = 0;
    logic [31:0] msg_w [0:31];

    always #5 clk = ~clk;

    assign all_rdy        = rdy[0] & rdy[1] & rdy[2];
    assign all_dv         = dv[0] & dv[1] & dv[2];
    assign in_valid_g     = in_valid_drv & all_rdy;
    assign digest_ready_g = digest_ready_drv & all_dv;

    sha256_stream_core #(.UNROLL(1), .LEN_W(64)) u_dut1 (
        .clk(clk), .reset(reset), .mode_224(mode_224), .in_data(in_data),
        .in_valid(in_valid_g), .in_ready(rdy[0]), .in_last(in_last), .in_bytes(in_bytes),
        .digest(dg[0]), .digest_valid(dv[0]), .digest_ready(digest_ready_g)
    );

    sha256_stream_core #(.UNROLL(2), .LEN_W(64)) u_dut2 (
        .clk(clk), .reset(reset), .mode_224(mode_224), .in_data(in_data),
        .in_valid(in_valid_g), .in_ready(rdy[1]), .in_last(in_last), .in_bytes(in_bytes),
        .digest(dg[1]), .digest_valid(dv[1]), .digest_ready(digest_ready_g)
    );

    sha256_stream_core #(.UNROLL(4), .LEN_W(32)) u_dut4 (
        .clk(clk), .reset(reset), .mode_224(mode_224), .in_data(in_data),
        .in_valid(in_valid_g), .in_ready(rdy[2]), .in_last(in_last), .in_bytes(in_bytes),
        .digest(dg[2]), .digest_valid(dv[2]), .digest_ready(digest_ready_g)
    );

    // ---------------------------------------------------------------- helpers
    task automatic send_beat(input logic [31:0] d, input bit last, input logic [2:0] nbytes,
                             input bit md, input bit stall);
        int waited = 0;
        while (!all_rdy && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!all_rdy) begin
            total++;
            $display("FAIL beat_accept: in_ready=%b after %0d cycles, required 1", all_rdy, waited);
        end else begin
            if (stall && $urandom_range(0, 1) == 1) begin
                in_valid_drv = 1'b0;
                in_data      = $urandom();
                @(negedge clk);
            end
            in_data      = d;
            in_last      = last;
            in_bytes     = nbytes;
            mode_224     = md;
            in_valid_drv = 1'b1;
            @(negedge clk);
            in_valid_drv = 1'b0;
            in_last      = 1'b0;
            in_data      = $urandom();
        end
    endtask

    task automatic send_msg(input int n, input logic [2:0] lastb, input bit md, input bit stall);
        for (int i = 0; i < n; i++) begin
            send_beat(msg_w[i], (i == n - 1), (i == n - 1) ? lastb : 3'd4, md, stall);
        end
    endtask

    task automatic wait_digest(output bit ok);
        int waited = 0;
        while (!all_dv && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        ok = all_dv;
        if (!ok) begin
            total++;
            $display("FAIL digest_timeout: digest_valid=%b%b%b after %0d cycles, required 111",
                     dv[0], dv[1], dv[2], waited);
        end
    endtask

    task automatic check_digests(input string name, input logic [255:0] exp);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (dg[k] !== exp)
                $display("FAIL %s dut%0d: digest=%h, required %h", name, k, dg[k], exp);
            else
                passed++;
        end
    endtask

    task automatic accept_digest(input string name);
        @(negedge clk);
        digest_ready_drv = 1'b1;
        @(negedge clk);
        digest_ready_drv = 1'b0;
        total++;
        if ({dv[0], dv[1], dv[2]} !== 3'b000)
            $display("FAIL %s_valid_drop: digest_valid=%b%b%b, required 000", name, dv[0], dv[1], dv[2]);
        else
            passed++;
        total++;
        if (all_rdy !== 1'b1)
            $display("FAIL %s_ready_return: in_ready=%b%b%b, required 111", name, rdy[0], rdy[1], rdy[2]);
        else
            passed++;
    endtask

    task automatic run_msg(input string name, input int n, input logic [2:0] lastb,
                           input bit md, input bit stall, input logic [255:0] exp);
        bit ok;
        send_msg(n, lastb, md, stall);
        wait_digest(ok);
        if (ok) check_digests(name, exp);
        accept_digest(name);
    endtask

    function automatic logic [31:0] chars4(input int first);
        logic [7:0] c;
        c = 8'h61 + 8'(first);
        return {c, c + 8'd1, c + 8'd2, c + 8'd3};
    endfunction

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset            = 1'b0;
        mode_224         = 1'b0;
        in_data          = '0;
        in_valid_drv     = 1'b0;
        in_last          = 1'b0;
        in_bytes         = '0;
        digest_ready_drv = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rdy[k] !== 1'b0 || dv[k] !== 1'b0 || dg[k] !== '0)
                $display("FAIL reset_outputs dut%0d: ready=%b valid=%b digest=%h, required 0 0 0",
                         k, rdy[k], dv[k], dg[k]);
            else
                passed++;
        end
        reset = 1'b1;
        #1;
        total++;
        if ({rdy[0], rdy[1], rdy[2]} !== 3'b000)
            $display("FAIL ready_before_first_edge: in_ready=%b%b%b, required 000", rdy[0], rdy[1], rdy[2]);
        else
            passed++;
        @(posedge clk);
        #1;
        total++;
        if (all_rdy !== 1'b1)
            $display("FAIL ready_after_first_edge: in_ready=%b%b%b, required 111", rdy[0], rdy[1], rdy[2]);
        else
            passed++;
        @(negedge clk);
    endtask

    task automatic test_empty();
        msg_w[0] = 32'hdead_beef;   // no valid bytes, content must be ignored
        run_msg("empty", 1, 3'd0, 1'b0, 1'b0, EXP_EMPTY);
    endtask

    task automatic test_abc();
        bit ok;
        int lat = 0;
        msg_w[0] = 32'h6162_6300;
        send_msg(1, 3'd3, 1'b0, 1'b0);
        while (dv[0] !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++;
        if (lat != 67)
            $display("FAIL abc_latency: digest_valid after %0d cycles, required 67", lat);
        else
            passed++;
        wait_digest(ok);
        if (ok) check_digests("abc", EXP_ABC);
        accept_digest("abc");
        // Unused low byte of a partial beat carries junk that must be masked.
        msg_w[0] = 32'h6162_63a5;
        run_msg("abc_masked", 1, 3'd3, 1'b0, 1'b0, EXP_ABC);
    endtask

    task automatic test_sha224();
        msg_w[0] = 32'h6162_6300;
        run_msg("abc224", 1, 3'd3, 1'b1, 1'b0, EXP_ABC224);
    endtask

    task automatic test_extra_block();
        for (int i = 0; i < 14; i++) msg_w[i] = chars4(i);
        run_msg("msg56", 14, 3'd4, 1'b0, 1'b0, EXP_56);
        run_msg("msg56_stall", 14, 3'd4, 1'b0, 1'b1, EXP_56);
        msg_w[14] = 32'h1234_5678;  // trailing empty last beat
        run_msg("msg56_empty_last", 15, 3'd0, 1'b0, 1'b0, EXP_56);
    endtask

    task automatic test_multi_block();
        for (int g = 0; g < 14; g++) begin
            msg_w[2*g]     = chars4(g);
            msg_w[2*g + 1] = chars4(g + 4);
        end
        run_msg("msg112", 28, 3'd4, 1'b0, 1'b1, EXP_112);
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad = 0;
        msg_w[0] = 32'h6162_6300;
        send_msg(1, 3'd3, 1'b0, 1'b0);
        wait_digest(ok);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                if (dg[k] !== EXP_ABC || rdy[k] !== 1'b0 || dv[k] !== 1'b1) bad++;
        end
        total++;
        if (!ok || bad != 0)
            $display("FAIL hold_stable: %0d unstable samples (valid=%b%b%b ready=%b%b%b), required 0",
                     bad, dv[0], dv[1], dv[2], rdy[0], rdy[1], rdy[2]);
        else
            passed++;
        accept_digest("hold_release");
        run_msg("abc_after_hold", 1, 3'd3, 1'b0, 1'b0, EXP_ABC);
    endtask

    task automatic test_reset_mid();
        msg_w[0] = 32'h6162_6300;
        send_msg(1, 3'd3, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rdy[k] !== 1'b0 || dv[k] !== 1'b0 || dg[k] !== '0)
                $display("FAIL abort_outputs dut%0d: ready=%b valid=%b digest=%h, required 0 0 0",
                         k, rdy[k], dv[k], dg[k]);
            else
                passed++;
        end
        @(negedge clk);
        reset = 1'b1;
        msg_w[0] = 32'h0;
        run_msg("empty_after_abort", 1, 3'd0, 1'b0, 1'b0, EXP_EMPTY);
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_sha224();
        test_extra_block();
        test_multi_block();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sha256_stream_core.md
Name: sha256_stream_core

Overview:
Next-generation SHA-256/SHA-224 hash engine that accepts an arbitrary-length byte message as a 32-bit word stream (valid/ready) rather than a fixed MSG_SIZE vector. It pads internally, processes any number of 512-bit blocks, and returns the digest over a valid/ready output. It replaces the fixed-width top-level hasher and is parametrised in rounds-per-cycle and length-counter width.

Parameters:
UNROLL, 1, compression rounds per clock; legal values 1, 2, 4. A compression pass takes 64/UNROLL cycles.
LEN_W, 64, message bit-length counter width; legal range 32..64. The appended length field is always 64 bits, zero-extended.

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
mode_224  input  1  1 selects SHA-224 IV and truncation; sampled on the first accepted beat of a message
in_data  input  32  message word, big-endian; first byte is in_data[31:24]
in_valid  input  1  in_data is valid
in_ready  output  1  core can accept in_data
in_last  input  1  beat is the final word of the message
in_bytes  input  3  valid bytes in a last beat, 0..4; ignored when in_last=0 (treated as 4)
digest  output  256  hash result; for SHA-224 the result is in [255:32] and [31:0]=0
digest_valid  output  1  digest is valid and held stable until accepted
digest_ready  input  1  consumer accepts digest

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, in_ready=0, digest_valid=0, digest=0, length counter=0, H registers=SHA-256 IV. The first in_ready=1 is in the cycle after reset deasserts.
- Beat handshake: a beat transfers when in_valid&&in_ready on a rising edge. in_ready=1 only in IDLE and LOAD.
- States:
  - IDLE: wait for the first beat. On the first beat, latch mode_224, load H with the matching IV, then go to LOAD.
  - LOAD: store beats into W[0..15] and add 8*bytes to the length counter.
    - After word 15, go to COMP.
    - On in_last, go to PAD, or to COMP if the last beat fills word 15 with 4 bytes.
  - PAD: takes one cycle.
    - Write 0x80 after the final byte, then zero-fill.
    - If bytes used in the block are 55 or fewer, place the 64-bit length in W[14..15] and set final_blk=1.
    - Otherwise set need_extra=1.
    - Go to COMP.
  - COMP: run 64/UNROLL cycles with a round counter and an on-the-fly message schedule over a 16-word circular window. Then go to UPD.
  - UPD: takes one cycle.
    - Compute H += a..h.
    - If final_blk, go to OUT.
    - If need_extra, build an all-zero block with the length in W[14..15], set final_blk, and go to COMP.
    - Otherwise go to LOAD.
  - OUT: digest_valid=1 and digest=H (truncated for 224). On digest_ready, go to IDLE, clear the counter, and deassert digest_valid the next cycle.
- Message ending exactly on a 64-byte boundary: after that block's UPD, go to PAD with an empty block. PAD writes 0x80, zeros and the length, and sets final_blk.
- Zero-length message: the first beat has in_last=1 and in_bytes=0. It produces a single padded block.
- in_bytes=0 with in_last on a non-first beat is legal and contributes no bytes.
- Partial last beat: bytes below the valid count are masked to zero before 0x80 is inserted.
- Latency for one block with UNROLL=1, from the last beat to digest_valid: PAD 1 + COMP 64 + UPD 1 + 1 = 67 cycles.
- A new message is not accepted while in OUT (in_ready=0).
- Reset mid-message or mid-compression aborts immediately. No partial digest is ever presented.
- All arithmetic is mod 2^32. The length counter wraps silently mod 2^LEN_W.

Decomposition:
- Package sha256_pkg: K[0:63] constant array, IV256/IV224 arrays, state enum, and functions ch, maj, bsig0, bsig1, ssig0, ssig1.
- Sub-module sha256_round (combinational): one round, from a..h, Wt and Kt to a'..h'. Instantiated UNROLL times in a chain.

Test Plan:
1. Empty message (one beat, in_last=1, in_bytes=0, mode_224=0) -> digest=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
2. "abc" (in_data=0x61626300, in_last=1, in_bytes=3) -> ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. With UNROLL=1, digest_valid rises exactly 67 cycles after the beat.
3. Same as test 2 with mode_224=1 -> digest[255:32]=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, digest[31:0]=0.
4. 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" in 14 beats -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. This exercises the extra padding block. Repeat for UNROLL=2 and UNROLL=4.
5. Backpressure:
   - Hold digest_ready=0 for 20 cycles after digest_valid: digest stays stable and in_ready=0.
   - Then pulse digest_ready: digest_valid drops the next cycle, and a new "abc" gives the correct digest.
   - Randomly toggle in_valid during test 4: the result is unchanged.
6. Assert reset during COMP of a "abc" run: in_ready, digest_valid and digest are 0 immediately. A subsequent empty message returns the test-1 digest.
